// File: rtl/rotsched_pkg.sv
// Shared types and width helper for the rotator scheduler slice.
// Imported by the interface, the arbiter and the top.
package rotsched_pkg;

  localparam int unsigned DefaultN = 4;

  // Data width is always a power of two so every amount 0..W-1 is a legal rotate.
  function automatic int unsigned data_width(int unsigned n);
    return 32'd1 << n;
  endfunction

  typedef enum logic {StEmpty, StFull} state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/rotator_scheduler_if.sv
// Request/response bundle between the two clients, the scheduler and the consumer.
// The master modport is the client/consumer side; the slave modport is the scheduler.
interface rotator_scheduler_if #(
  parameter int unsigned N = 4
);
  import rotsched_pkg::*;

  localparam int unsigned W = data_width(N);

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_data0;
  logic [N-1:0] req_amt0;
  logic [W-1:0] req_data1;
  logic [N-1:0] req_amt1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  req_id_t      rsp_id;

  modport master (
    output req_valid, req_data0, req_amt0, req_data1, req_amt1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data0, req_amt0, req_data1, req_amt1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the caller owns and advances the priority pointer.
// Grant is one-hot or zero and is purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/rotator_scheduler.sv
// Shares one rotate-right datapath between two requesters, round-robin arbitrated,
// with a single-entry result register tagged by requester id.
module rotator_scheduler
  import rotsched_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input logic                clk,
  input logic                reset,
  rotator_scheduler_if.slave bus
);

  localparam int unsigned W = data_width(N);

  state_e       state_q;
  logic         ptr_q;
  logic [W-1:0] data_q;
  req_id_t      id_q;

  logic         can_accept;
  logic [1:0]   gnt;
  logic [W-1:0] sel_data;
  logic [N-1:0] sel_amt;
  logic [W-1:0] rot;

  assign can_accept = (state_q == StEmpty) | bus.rsp_ready;

  // Reset gates the enable so nothing looks accepted during a reset cycle.
  rr_arb2 u_arb (
    .req    (bus.req_valid),
    .enable (can_accept & ~reset),
    .ptr    (ptr_q),
    .gnt    (gnt)
  );

  // Rotating a doubled word right and keeping the low half gives rotate-right
  // without a special case for amt = 0.
  always_comb begin
    sel_data = gnt[1] ? bus.req_data1 : bus.req_data0;
    sel_amt  = gnt[1] ? bus.req_amt1  : bus.req_amt0;
    rot      = W'({sel_data, sel_data} >> sel_amt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      ptr_q   <= 1'b0;
      data_q  <= '0;
      id_q    <= 1'b0;
    end else if (|gnt) begin
      state_q <= StFull;
      data_q  <= rot;
      id_q    <= gnt[1];
      ptr_q   <= ~gnt[1];
    end else if (bus.rsp_ready) begin
      state_q <= StEmpty;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state_q == StFull);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_rotator_scheduler.sv
// Scoreboard bench for rotator_scheduler: directed scenarios followed by random traffic,
// checked against a behavioural arbitration/rotation model.
module tb_rotator_scheduler;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] data;
    logic         id;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rotator_scheduler_if #(.N(N)) bus ();

  rotator_scheduler #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  rsp_t sbq[$];

  // Model state: who has priority when both ask, and whether the buffer is occupied.
  logic       ptr_m  = 1'b0;
  bit         full_m = 1'b0;
  logic [1:0] exp_g;
  bit         can_m;
  rsp_t       pend_item;
  bit         push_pend  = 1'b0;
  bit         flush_pend = 1'b0;
  logic [1:0] acc;

  function automatic logic [W-1:0] rot_ref(logic [W-1:0] a, int amt);
    int unsigned x;
    x = a;
    return W'(((x >> amt) | (x << (W - amt))) & 32'h0000_FFFF);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected grant from the arbitration rules, expected result pushed
  // into the scoreboard once the accepting edge has passed.
  always @(negedge clk) begin
    if (reset) begin
      exp_g = 2'b00;
    end else begin
      can_m = !full_m || bus.rsp_ready;
      exp_g = 2'b00;
      if (can_m) begin
        if (bus.req_valid == 2'b11)      exp_g = ptr_m ? 2'b10 : 2'b01;
        else if (bus.req_valid == 2'b01) exp_g = 2'b01;
        else if (bus.req_valid == 2'b10) exp_g = 2'b10;
      end
    end
    check("req_ready", 32'(bus.req_ready), 32'(exp_g));
    if (reset) begin
      full_m     = 1'b0;
      ptr_m      = 1'b0;
      flush_pend = 1'b1;
    end else if (exp_g != 2'b00) begin
      if (exp_g[1]) pend_item = '{data: rot_ref(bus.req_data1, int'(bus.req_amt1)), id: 1'b1};
      else          pend_item = '{data: rot_ref(bus.req_data0, int'(bus.req_amt0)), id: 1'b0};
      push_pend = 1'b1;
      ptr_m     = ~exp_g[1];
      full_m    = 1'b1;
    end else if (bus.rsp_ready) begin
      full_m = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (flush_pend) sbq.delete();
    if (push_pend) sbq.push_back(pend_item);
    flush_pend = 1'b0;
    push_pend  = 1'b0;
  end

  // Monitor: the buffer must hold exactly the oldest unconsumed expected result.
  always @(negedge clk) begin
    if (!reset) begin
      check("rsp_valid", 32'(bus.rsp_valid), 32'(sbq.size() != 0));
      if (bus.rsp_valid && sbq.size() != 0) begin
        check("rsp_data", 32'(bus.rsp_data), 32'(sbq[0].data));
        check("rsp_id", 32'(bus.rsp_id), 32'(sbq[0].id));
        if (bus.rsp_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic drive(logic rst, logic [1:0] v, logic [W-1:0] d0, logic [N-1:0] a0,
                       logic [W-1:0] d1, logic [N-1:0] a1, logic rr);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.req_valid = v;
    bus.req_data0 = d0;
    bus.req_amt0  = a0;
    bus.req_data1 = d1;
    bus.req_amt1  = a1;
    bus.rsp_ready = rr;
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_data0 = 16'h1111;
    bus.req_amt0  = 4'd3;
    bus.req_data1 = 16'h2222;
    bus.req_amt1  = 4'd5;
    bus.rsp_ready = 1'b1;

    // Reset held two cycles with both requesters asking.
    @(posedge clk);
    drive(1'b0, 2'b00, 16'h0, 4'd0, 16'h0, 4'd0, 1'b1);
    @(negedge clk);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'h0000);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);

    // Single request.
    drive(1'b0, 2'b01, 16'h0001, 4'd1, 16'h0, 4'd0, 1'b1);
    drive(1'b0, 2'b00, 16'h0, 4'd0, 16'h0, 4'd0, 1'b1);
    drive(1'b0, 2'b00, 16'h0, 4'd0, 16'h0, 4'd0, 1'b1);

    // Contention from a fresh pointer: grants alternate starting with requester 0.
    drive(1'b1, 2'b00, 16'h0, 4'd0, 16'h0, 4'd0, 1'b1);
    repeat (4) drive(1'b0, 2'b11, 16'hF000, 4'd4, 16'h1234, 4'd8, 1'b1);

    // Backpressure: fill, stall three cycles, then drain and accept together.
    drive(1'b0, 2'b11, 16'hF000, 4'd4, 16'h1234, 4'd8, 1'b0);
    repeat (2) drive(1'b0, 2'b11, 16'hF000, 4'd4, 16'h1234, 4'd8, 1'b0);
    drive(1'b0, 2'b11, 16'hF000, 4'd4, 16'h1234, 4'd8, 1'b1);
    drive(1'b0, 2'b00, 16'h0, 4'd0, 16'h0, 4'd0, 1'b1);
    drive(1'b0, 2'b00, 16'h0, 4'd0, 16'h0, 4'd0, 1'b1);

    // Amount boundaries.
    drive(1'b0, 2'b01, 16'hA5C3, 4'd0, 16'h0, 4'd0, 1'b1);
    drive(1'b0, 2'b10, 16'h0, 4'd0, 16'h0001, 4'd15, 1'b1);
    drive(1'b0, 2'b01, 16'h00FF, 4'd8, 16'h0, 4'd0, 1'b1);
    drive(1'b0, 2'b00, 16'h0, 4'd0, 16'h0, 4'd0, 1'b1);

    // Mid-operation reset while full and stalled; pointer must return to 0.
    drive(1'b0, 2'b10, 16'h0, 4'd0, 16'hBEEF, 4'd4, 1'b0);
    drive(1'b0, 2'b11, 16'h1357, 4'd2, 16'hBEEF, 4'd4, 1'b0);
    drive(1'b1, 2'b11, 16'h1357, 4'd2, 16'hBEEF, 4'd4, 1'b0);
    drive(1'b0, 2'b11, 16'h1357, 4'd2, 16'hBEEF, 4'd4, 1'b0);
    drive(1'b0, 2'b11, 16'h1357, 4'd2, 16'hBEEF, 4'd4, 1'b1);
    drive(1'b0, 2'b00, 16'h0, 4'd0, 16'h0, 4'd0, 1'b1);

    // Random traffic: operands held until accepted, occasional withdrawal.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && !acc[i]) begin
          if ($urandom_range(15) == 0) bus.req_valid[i] = 1'b0;
        end else begin
          bus.req_valid[i] = 1'($urandom_range(1));
          if (i == 0) begin
            bus.req_data0 = 16'($urandom);
            bus.req_amt0  = 4'($urandom);
          end else begin
            bus.req_data1 = 16'($urandom);
            bus.req_amt1  = 4'($urandom);
          end
        end
      end
      bus.rsp_ready = ($urandom_range(3) != 0);
    end

    repeat (4) drive(1'b0, 2'b00, 16'h0, 4'd0, 16'h0, 4'd0, 1'b1);
    @(negedge clk);
    check("drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rotator_scheduler.md
# rotator_scheduler

Two-port scheduler that shares one 2**N-bit rotate-right datapath between two requesters. Each requester presents an operand and rotate amount over a valid/ready handshake. The block arbitrates round-robin, computes the rotation, and holds the result in a single-entry output register tagged with the requester id. It sits between two client blocks and the downstream consumer of rotated words.

## Interface
Parameters:
- N, default 4: log2 of data width. Data width W = 2**N; amount width N.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- req_valid  input  2  bit i: requester i offers an operation
- req_ready  output  2  bit i: requester i's operation is accepted this cycle (one-hot or zero)
- req_data0  input  W  requester 0 operand
- req_amt0  input  N  requester 0 rotate amount
- req_data1  input  W  requester 1 operand
- req_amt1  input  N  requester 1 rotate amount
- rsp_valid  output  1  output register holds a result
- rsp_ready  input  1  consumer takes the result this cycle
- rsp_data  output  W  rotated result
- rsp_id  output  1  requester that produced rsp_data

## Operation
- One clock domain; reset is synchronous and active-high.
- Rotation: rsp_data = (a >> amt) | (a << (W - amt)), where amt = 0 means pass-through. All amounts 0..W-1 are legal. No other arithmetic is performed.
- FSM states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = (state==EMPTY) | rsp_ready.
- Grant:
  - If can_accept and exactly one req_valid bit is set, that requester is granted.
  - If both are set, the requester equal to priority pointer ptr is granted.
  - If can_accept=0, there is no grant.
- req_ready = grant vector, one-hot or 00. It is combinational from req_valid, state, rsp_ready and ptr.
- On grant to i: the output register loads rot(data_i, amt_i), rsp_id <= i, and ptr <= ~i.
- ptr is unchanged when there is no grant. Ptr advances after any grant, contested or not.
- Transitions:
  - EMPTY & grant -> FULL.
  - EMPTY & no grant -> EMPTY.
  - FULL & rsp_ready & grant -> FULL (buffer replaced; back-to-back throughput of 1 per cycle).
  - FULL & rsp_ready & no grant -> EMPTY.
  - FULL & !rsp_ready -> FULL; rsp_data and rsp_id are held stable and req_ready=00.
- Requesters must hold valid, data and amt stable until accepted. A deasserted valid withdraws the request; no error is raised.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, ptr=0, state=EMPTY. req_ready=00 while reset is high.
- Latency: an operation accepted in cycle t appears with rsp_valid=1 in cycle t+1.
- Throughput: one operation per cycle while rsp_ready=1.
- Simultaneous drain and accept in FULL: the old result is consumed and the new result is visible next cycle, with no bubble.
- Reset asserted while FULL: the buffered result is discarded and rsp_valid=0 on the next cycle. An operation with req_ready high in the reset cycle is not accepted.
- No combinational path from req_data/req_amt to rsp_*. The rotator output feeds the register only.

## Structure
- Package rotsched_pkg holds:
  - the state enum typedef (EMPTY, FULL);
  - localparam function or constant for W from N;
  - a requester-id typedef.
- Sub-module rr_arb2: two-input round-robin arbiter. Inputs are req[1:0], enable (= can_accept) and ptr. Output is the one-hot grant. The parent owns the ptr register.
- Rotation is inline combinational logic in the parent, selected by the grant mux.

## Test plan
Use N=4 (W=16) for all scenarios.
- Reset check: hold reset 2 cycles with req_valid=11. Required: req_ready=00 during reset; rsp_valid=0, rsp_data=0x0000, rsp_id=0 after release.
- Single request: req_valid=01, data0=0x0001, amt0=1. Required: req_ready=01 that cycle; next cycle rsp_valid=1, rsp_data=0x8000, rsp_id=0.
- Contention with rsp_ready=1: req_valid=11 held, data0=0xF000 amt0=4, data1=0x1234 amt1=8. Required: grants alternate 01,10,01,10. Responses alternate 0x0F00 (id 0) and 0x3412 (id 1) on consecutive cycles.
- Backpressure: fill the buffer, then hold rsp_ready=0 for 3 cycles with req_valid=11. Required: req_ready=00 and rsp_data/rsp_id constant. When rsp_ready=1 is raised, the drain and the next grant occur in the same cycle.
- Amount boundaries: amt=0 with data 0xA5C3 gives 0xA5C3. amt=15 with data 0x0001 gives 0x0002. amt=8 with data 0x00FF gives 0xFF00.
- Mid-operation reset: reset while FULL with rsp_ready=0. Required: rsp_valid=0 next cycle and ptr=0. The first contested grant after release goes to requester 0.
